read_rectangle_sp: RTL and testbench

- Reader counterpart to the superpixel rectangle writer: reads back the colour ID of every superpixel inside a superpixel-coordinate rectangle from the VGA frame RAM.
- Samples each superpixel at its top-left physical pixel, one RAM read per superpixel, in raster order.
- Streams the results out with valid/ready handshake; a credit-limited FIFO absorbs the fixed RAM read latency.
- Sits between user logic (collision checks, screen readback/copy) and the frame RAM read port.

---
 rtl/read_rectangle_sp_if.sv | 37 +++
 rtl/read_rectangle_sp.sv | 195 +++++++++++++++++++
 tb/tb_read_rectangle_sp.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/read_rectangle_sp_if.sv
// Bus bundle for the superpixel rectangle reader.
// Groups the request, frame-RAM read port and
// result stream; slave = reader, master = user/RAM side.
interface read_rectangle_sp_if #(
    parameter int SPIXEL_X_WIDTH = 6,
    parameter int SPIXEL_Y_WIDTH = 6,
    parameter int VGA_ADDR_WIDTH = 19,
    parameter int COLOR_ID_WIDTH = 8
);
    logic [SPIXEL_X_WIDTH-1:0] x0;
    logic [SPIXEL_Y_WIDTH-1:0] y0;
    logic [SPIXEL_X_WIDTH-1:0] x1;
    logic [SPIXEL_Y_WIDTH-1:0] y1;
    logic                      istart;
    logic                      obusy;
    logic                      odone;
    logic [VGA_ADDR_WIDTH-1:0] oaddr;
    logic                      ordren;
    logic [COLOR_ID_WIDTH-1:0] irdata;
    logic [COLOR_ID_WIDTH-1:0] odata;
    logic [SPIXEL_X_WIDTH-1:0] ox;
    logic [SPIXEL_Y_WIDTH-1:0] oy;
    logic                      ovld;
    logic                      irdy;

    modport slave (
        input  x0, y0, x1, y1, istart, irdata, irdy,
        output obusy, odone, oaddr, ordren,
        output odata, ox, oy, ovld
    );

    modport master (
        output x0, y0, x1, y1, istart, irdata, irdy,
        input  obusy, odone, oaddr, ordren,
        input  odata, ox, oy, ovld
    );
endinterface

// File: rtl/read_rectangle_sp.sv
// Reads the colour ID of every superpixel in a rectangle.
// Ports: clk, rst (async active-low), bus (slave: request,
// frame-RAM read port, valid/ready result stream).
module read_rectangle_sp #(
    parameter int SPIXEL_X_WIDTH = 6,
    parameter int SPIXEL_Y_WIDTH = 6,
    parameter logic [SPIXEL_X_WIDTH-1:0] SPIXEL_X_MAX = 6'd63,
    parameter logic [SPIXEL_Y_WIDTH-1:0] SPIXEL_Y_MAX = 6'd47,
    parameter int SPIXEL_SIZE    = 10,
    parameter int PIXEL_X_RES    = 640,
    parameter int VGA_ADDR_WIDTH = 19,
    parameter int COLOR_ID_WIDTH = 8,
    parameter int RD_LATENCY     = 2,
    parameter int FIFO_DEPTH     = 4
) (
    input logic clk,
    input logic rst,
    read_rectangle_sp_if.slave bus
);
    localparam int XW = SPIXEL_X_WIDTH;
    localparam int YW = SPIXEL_Y_WIDTH;
    localparam int AW = VGA_ADDR_WIDTH;
    localparam int DW = COLOR_ID_WIDTH;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW-1:0] ROW_STEP = AW'(SPIXEL_SIZE * PIXEL_X_RES);
    localparam logic [AW-1:0] COL_STEP = AW'(SPIXEL_SIZE);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic [XW-1:0] x0_q, x1_q, sx;
    logic [YW-1:0] y0_q, y1_q, sy;
    logic [XW-1:0] x0_c, x1_c;
    logic [YW-1:0] y0_c, y1_c;
    logic [CW-1:0] outst, cnt;
    logic [CW:0]   inflight;
    logic          credit, issue, last, ret, push, pop;
    logic          obusy, odone, ordren;

    logic [RD_LATENCY-1:0] tag_vld;
    logic [XW-1:0] tag_x [RD_LATENCY];
    logic [YW-1:0] tag_y [RD_LATENCY];

    logic [DW-1:0] mem_d [FIFO_DEPTH];
    logic [XW-1:0] mem_x [FIFO_DEPTH];
    logic [YW-1:0] mem_y [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;

    assign x0_c = (bus.x0 > SPIXEL_X_MAX) ? SPIXEL_X_MAX : bus.x0;
    assign x1_c = (bus.x1 > SPIXEL_X_MAX) ? SPIXEL_X_MAX : bus.x1;
    assign y0_c = (bus.y0 > SPIXEL_Y_MAX) ? SPIXEL_Y_MAX : bus.y0;
    assign y1_c = (bus.y1 > SPIXEL_Y_MAX) ? SPIXEL_Y_MAX : bus.y1;

    // Reads in flight plus queued results never exceed FIFO space,
    // so every returning read has a slot waiting for it.
    assign inflight = (CW+1)'(outst) + (CW+1)'(cnt);
    assign credit   = inflight < (CW+1)'(FIFO_DEPTH);
    assign issue    = (state == ISSUE) && credit;
    assign last     = (sx == x1_q) && (sy == y1_q);
    assign ret      = tag_vld[RD_LATENCY-1];
    assign push     = ret;
    assign pop      = (cnt != '0) && bus.irdy;

    always_comb begin
        state_nxt = state;
        obusy     = 1'b0;
        odone     = 1'b0;
        ordren    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.istart) begin
                    if ((x1_c < x0_c) || (y1_c < y0_c)) state_nxt = DONE;
                    else                                state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                obusy = 1'b1;
                if (credit) begin
                    ordren = 1'b1;
                    if (last) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                obusy = 1'b1;
                // Finish as soon as the final element is being accepted.
                if ((outst == '0) &&
                    ((cnt == '0) || ((cnt == CW'(1)) && pop)))
                    state_nxt = DONE;
            end
            DONE: begin
                odone     = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            x0_q  <= '0;
            x1_q  <= '0;
            y0_q  <= '0;
            y1_q  <= '0;
            sx    <= '0;
            sy    <= '0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && bus.istart) begin
                x0_q <= x0_c;
                x1_q <= x1_c;
                y0_q <= y0_c;
                y1_q <= y1_c;
                sx   <= x0_c;
                sy   <= y0_c;
            end else if (issue) begin
                if (sx == x1_q) begin
                    sx <= x0_q;
                    sy <= sy + YW'(1);
                end else begin
                    sx <= sx + XW'(1);
                end
            end
        end
    end

    // Coordinates ride alongside each read until its data returns.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_vld <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                tag_x[i] <= '0;
                tag_y[i] <= '0;
            end
        end else begin
            tag_vld[0] <= issue;
            tag_x[0]   <= sx;
            tag_y[0]   <= sy;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_x[i]   <= tag_x[i-1];
                tag_y[i]   <= tag_y[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outst <= '0;
        end else begin
            unique case ({issue, ret})
                2'b10:   outst <= outst + CW'(1);
                2'b01:   outst <= outst - CW'(1);
                default: outst <= outst;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_d[i] <= '0;
                mem_x[i] <= '0;
                mem_y[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_d[wr_ptr] <= bus.irdata;
                mem_x[wr_ptr] <= tag_x[RD_LATENCY-1];
                mem_y[wr_ptr] <= tag_y[RD_LATENCY-1];
                wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH-1)) ? '0 : wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH-1)) ? '0 : rd_ptr + PW'(1);
            unique case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign bus.obusy  = obusy;
    assign bus.odone  = odone;
    assign bus.ordren = ordren;
    assign bus.oaddr  = ordren ? (AW'(sy) * ROW_STEP + AW'(sx) * COL_STEP)
                               : '0;
    assign bus.ovld   = (cnt != '0);
    assign bus.odata  = bus.ovld ? mem_d[rd_ptr] : '0;
    assign bus.ox     = bus.ovld ? mem_x[rd_ptr] : '0;
    assign bus.oy     = bus.ovld ? mem_y[rd_ptr] : '0;
endmodule

// File: tb/tb_read_rectangle_sp.sv
// Scoreboard bench for the superpixel rectangle reader.
// Directed rectangles; RAM model with 2-cycle read latency.
module tb_read_rectangle_sp;
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   t0 = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   done_cnt = 0;
    int   exp_done_rel = -1;

    typedef struct {
        logic [18:0] a;
        int          c;
    } rd_t;

    typedef struct {
        logic [7:0] d;
        logic [5:0] x;
        logic [5:0] y;
        int         c;
    } out_t;

    rd_t  exp_rd[$];
    out_t exp_out[$];

    read_rectangle_sp_if bus();

    read_rectangle_sp dut (
        .clk(clk),
        .rst(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] ram(input logic [18:0] a);
        if (a == 19'd12830) return 8'h5A;
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    logic [7:0] rp1 = '0, rp2 = '0;
    always @(posedge clk) begin
        rp1 <= bus.ordren ? ram(bus.oaddr) : 8'h00;
        rp2 <= rp1;
    end
    assign bus.irdata = rp2;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents something.
    logic       hold_v = 1'b0;
    logic [7:0] hold_d;
    logic [5:0] hold_x, hold_y;
    rd_t        er;
    out_t       eo;

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            if (bus.ordren) begin
                if (exp_rd.size() == 0) begin
                    chk("unexpected_read", bus.oaddr, 32'hFFFF_FFFF);
                end else begin
                    er = exp_rd.pop_front();
                    chk("rd_addr", bus.oaddr, er.a);
                    chk("rd_cyc", cyc - t0, er.c);
                end
            end
            if (hold_v) begin
                chk("hold_vld", bus.ovld, 1);
                chk("hold_data", {bus.odata, bus.ox, bus.oy},
                    {hold_d, hold_x, hold_y});
            end
            hold_v = bus.ovld && !bus.irdy;
            hold_d = bus.odata;
            hold_x = bus.ox;
            hold_y = bus.oy;
            if (bus.ovld && bus.irdy) begin
                if (exp_out.size() == 0) begin
                    chk("unexpected_out", bus.odata, 32'hFFFF_FFFF);
                end else begin
                    eo = exp_out.pop_front();
                    chk("out_data", bus.odata, eo.d);
                    chk("out_xy", {bus.ox, bus.oy}, {eo.x, eo.y});
                    if (eo.c >= 0) chk("out_cyc", cyc - t0, eo.c);
                end
            end
            if (bus.odone) begin
                done_cnt++;
                if (exp_done_rel >= 0) chk("done_cyc", cyc - t0, exp_done_rel);
            end
        end
    end

    task automatic exp_r(input logic [18:0] a, input int c);
        rd_t r;
        r.a = a;
        r.c = c;
        exp_rd.push_back(r);
    endtask

    task automatic exp_o(input logic [7:0] d, input logic [5:0] x,
                         input logic [5:0] y, input int c);
        out_t o;
        o.d = d;
        o.x = x;
        o.y = y;
        o.c = c;
        exp_out.push_back(o);
    endtask

    task automatic start(input logic [5:0] ax0, input logic [5:0] ay0,
                         input logic [5:0] ax1, input logic [5:0] ay1);
        @(posedge clk);
        #1;
        done_cnt = 0;
        bus.x0 = ax0;
        bus.y0 = ay0;
        bus.x1 = ax1;
        bus.y1 = ay1;
        bus.istart = 1'b1;
        t0 = cyc;
        @(posedge clk);
        #1;
        bus.istart = 1'b0;
    endtask

    task automatic wait_done(input logic exp_busy);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (cyc - t0 == 1) chk("busy_c1", bus.obusy, exp_busy);
            if (done_cnt > 0) break;
        end
        if (done_cnt == 0) chk("done_timeout", 0, 1);
        repeat (2) @(negedge clk);
        chk("done_once", done_cnt, 1);
        chk("rd_left", exp_rd.size(), 0);
        chk("out_left", exp_out.size(), 0);
    endtask

    task automatic rect_expect();
        exp_r(19'd0, 1);
        exp_r(19'd10, 2);
        exp_r(19'd6400, 3);
        exp_r(19'd6410, 4);
        exp_o(8'h3C, 6'd0, 6'd0, 4);
        exp_o(8'h36, 6'd1, 6'd0, 5);
        exp_o(8'h25, 6'd0, 6'd1, 6);
        exp_o(8'h2F, 6'd1, 6'd1, 7);
        exp_done_rel = 8;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, bus.obusy, 0);
        chk({tag, "_done"}, bus.odone, 0);
        chk({tag, "_rden"}, bus.ordren, 0);
        chk({tag, "_addr"}, bus.oaddr, 0);
        chk({tag, "_vld"}, bus.ovld, 0);
        chk({tag, "_out"}, {bus.odata, bus.ox, bus.oy}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.x0 = '0;
        bus.y0 = '0;
        bus.x1 = '0;
        bus.y1 = '0;
        bus.istart = 1'b0;
        bus.irdy = 1'b1;
        #2;
        chk_zero("rst");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single superpixel.
        exp_r(19'd12830, 1);
        exp_o(8'h5A, 6'd3, 6'd2, 4);
        exp_done_rel = 5;
        start(6'd3, 6'd2, 6'd3, 6'd2);
        wait_done(1'b1);

        // 2x2 rectangle at full throughput.
        rect_expect();
        start(6'd0, 6'd0, 6'd1, 6'd1);
        wait_done(1'b1);

        // Same rectangle, consumer stalled for 10 cycles.
        exp_r(19'd0, 1);
        exp_r(19'd10, 2);
        exp_r(19'd6400, 3);
        exp_r(19'd6410, 4);
        exp_o(8'h3C, 6'd0, 6'd0, 10);
        exp_o(8'h36, 6'd1, 6'd0, 11);
        exp_o(8'h25, 6'd0, 6'd1, 12);
        exp_o(8'h2F, 6'd1, 6'd1, 13);
        exp_done_rel = 14;
        bus.irdy = 1'b0;
        start(6'd0, 6'd0, 6'd1, 6'd1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        #1;
        chk("stall_vld", bus.ovld, 1);
        chk("stall_head", {bus.odata, bus.ox, bus.oy},
            {8'h3C, 6'd0, 6'd0});
        @(posedge clk);
        #1;
        bus.irdy = 1'b1;
        wait_done(1'b1);

        // Bottom-right corner with out-of-range y1.
        exp_r(19'd301430, 1);
        exp_o(8'hD3, 6'd63, 6'd47, 4);
        exp_done_rel = 5;
        start(6'd63, 6'd47, 6'd63, 6'd60);
        wait_done(1'b1);

        // Inverted rectangle: no reads, immediate done.
        exp_done_rel = 1;
        start(6'd5, 6'd0, 6'd2, 6'd0);
        wait_done(1'b0);

        // Reset in the middle of issuing.
        rect_expect();
        start(6'd0, 6'd0, 6'd1, 6'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_zero("abort");
        exp_rd.delete();
        exp_out.delete();
        exp_done_rel = -1;
        done_cnt = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_no_done", done_cnt, 0);
        chk("abort_idle", {bus.obusy, bus.ovld, bus.ordren}, 0);

        // Fresh run after reset.
        rect_expect();
        start(6'd0, 6'd0, 6'd1, 6'd1);
        wait_done(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
